// File: rtl/noc_arb_pkg.sv
// Shared types and constants for the NoC output-stage weighted round-robin arbiter.
package noc_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam int unsigned DEF_N_REQ   = 5;
    localparam int unsigned DEF_QUANTUM = 4;

    // Counter width that never collapses to zero bits.
    function automatic int unsigned safe_clog2(input int unsigned v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/wrr_arbiter_if.sv
// Request/acknowledge and grant bundle between the VC buffers and the output arbiter.
interface wrr_arbiter_if #(
    parameter int unsigned N_REQ = noc_arb_pkg::DEF_N_REQ,
    parameter int unsigned IDX_W = $clog2(N_REQ)
);
    logic [N_REQ-1:0] req;
    logic             ack;
    logic             tail;
    logic             grant_vld;
    logic [N_REQ-1:0] grant_oh;
    logic [IDX_W-1:0] grant_idx;

    modport master (
        output req, ack, tail,
        input  grant_vld, grant_oh, grant_idx
    );

    modport slave (
        input  req, ack, tail,
        output grant_vld, grant_oh, grant_idx
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational circular priority picker: first set bit of mask searching upward from ptr+1.
module rr_pick #(
    parameter int unsigned N_REQ = 5,
    parameter int unsigned IDX_W = 3
) (
    input  logic [N_REQ-1:0] mask,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx,
    output logic [N_REQ-1:0] oh
);

    int unsigned c;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        oh    = '0;
        c     = 0;
        // Walk from farthest to nearest so the nearest hit is the one that sticks.
        for (int unsigned i = N_REQ; i > 0; i--) begin
            c = 32'(ptr) + i;
            if (c >= N_REQ) c = c - N_REQ;
            if (mask[c]) begin
                found = 1'b1;
                idx   = IDX_W'(c);
                oh    = '0;
                oh[c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wrr_arbiter.sv
// Quantum-based round-robin output arbiter with registered, bubble-free grant handover.
// Optional WRR_ARB_PKT_LOCK_EN: quantum counts whole packets (ack && tail) instead of flits.
module wrr_arbiter
    import noc_arb_pkg::*;
#(
    parameter int unsigned N_REQ   = DEF_N_REQ,
    parameter int unsigned QUANTUM = DEF_QUANTUM,
    parameter int unsigned IDX_W   = $clog2(N_REQ)
) (
    input logic          clk,
    input logic          reset_n,
    wrr_arbiter_if.slave bus
);

    localparam int unsigned      CNT_W    = safe_clog2(QUANTUM);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUANTUM - 1);

    arb_state_e       state_q;
    logic [IDX_W-1:0] owner_q;
    logic [IDX_W-1:0] ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             vld_q;
    logic [N_REQ-1:0] oh_q;

    logic             all_found, oth_found;
    logic [IDX_W-1:0] all_idx, oth_idx;
    logic [N_REQ-1:0] all_oh, oth_oh;
    logic [N_REQ-1:0] oth_mask;
    logic             cnt_ev;

    assign oth_mask = bus.req & ~oh_q;

    rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick_all (
        .mask  (bus.req),
        .ptr   (ptr_q),
        .found (all_found),
        .idx   (all_idx),
        .oh    (all_oh)
    );

    rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick_oth (
        .mask  (oth_mask),
        .ptr   (ptr_q),
        .found (oth_found),
        .idx   (oth_idx),
        .oh    (oth_oh)
    );

`ifdef WRR_ARB_PKT_LOCK_EN
    assign cnt_ev = bus.ack & bus.tail;
`else
    logic unused_tail;
    assign unused_tail = bus.tail;
    assign cnt_ev      = bus.ack;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            ptr_q   <= IDX_W'(N_REQ - 1);
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            oh_q    <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (all_found) begin
                        state_q <= ARB_GRANT;
                        owner_q <= all_idx;
                        ptr_q   <= all_idx;
                        cnt_q   <= '0;
                        vld_q   <= 1'b1;
                        oh_q    <= all_oh;
                    end
                end
                ARB_GRANT: begin
                    if (!bus.req[owner_q]) begin
                        cnt_q <= '0;
                        if (all_found) begin
                            owner_q <= all_idx;
                            ptr_q   <= all_idx;
                            oh_q    <= all_oh;
                        end else begin
                            state_q <= ARB_IDLE;
                            owner_q <= '0;
                            vld_q   <= 1'b0;
                            oh_q    <= '0;
                        end
                    end else if (cnt_ev && cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (oth_found) begin
                            owner_q <= oth_idx;
                            ptr_q   <= oth_idx;
                            oh_q    <= oth_oh;
                        end
                    end else if (cnt_ev) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    owner_q <= '0;
                    vld_q   <= 1'b0;
                    oh_q    <= '0;
                end
            endcase
        end
    end

    assign bus.grant_vld = vld_q;
    assign bus.grant_oh  = oh_q;
    assign bus.grant_idx = owner_q;

endmodule

// File: doc/wrr_arbiter.md
# wrr_arbiter

Parametrised round-robin output arbiter for the NoC router output stage. It selects one of `N_REQ` virtual-channel buffers, typically 4 VCs plus a local port. The selected buffer holds the output for up to `QUANTUM` accepted transfers, then the grant rotates to the next requester. The grant is registered and held across consecutive transfers. It switches directly from one owner to the next with no idle bubble, and drops to idle only when no input is requesting.

## Interface
Parameters:
- `N_REQ`, default 5: number of requesters; must be ≥ 2.
- `QUANTUM`, default 4: accepted transfers per turn; must be ≥ 1.
- `IDX_W`, default `$clog2(N_REQ)`: width of the grant index.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `req`  in  `N_REQ`  request per buffer; a buffer asserts its bit when it is non-empty.
- `ack`  in  1  downstream consumed one flit from the current owner this cycle.
- `tail`  in  1  the acked flit is the last flit of a packet; qualified by `ack`.
- `grant_vld`  out  1  an owner is selected.
- `grant_oh`  out  `N_REQ`  one-hot owner; all zero when idle.
- `grant_idx`  out  `IDX_W`  binary owner index; 0 when idle.

## Operation
State:
- FSM with two states: `IDLE` and `GRANT`.
- `owner` register, `ptr` register (last owner), and burst counter `cnt` of width `max(1,$clog2(QUANTUM))`.
- All outputs decode from registers only.

Reset:
- State `IDLE`, `ptr = N_REQ-1`, `cnt = 0`.
- `grant_vld = 0`, `grant_oh = 0`, `grant_idx = 0`.

Pick function:
- Returns the first set bit of a mask, searching circularly from `ptr+1` upward and wrapping from `N_REQ-1` to 0.

`IDLE`:
- If `req` is non-zero, go to `GRANT` with `owner = pick(req)`, `ptr = owner`, `cnt = 0`.

`GRANT`, evaluated in this priority order:
1. If `req[owner] = 0`:
   - Pick from `req`. If a requester is found, it becomes the new owner with `cnt = 0`; otherwise go to `IDLE`.
   - `ack` is ignored in this cycle.
2. Else if the count event occurs and `cnt == QUANTUM-1`:
   - `cnt = 0`.
   - If `req & ~grant_oh` is non-zero, switch owner to `pick(req & ~grant_oh)`.
   - Otherwise the same owner continues.
3. Else if the count event occurs: `cnt++`.

Count event:
- `ack` (see Configuration for the alternative definition).
- `ack` while `grant_vld = 0` is ignored.

General rules:
- `ptr` updates to every newly granted owner; after an idle period, priority resumes after the last owner.
- The grant is never split; exactly one `grant_oh` bit is set whenever `grant_vld = 1`.

## Timing
- Request-to-grant latency: `req` rising in cycle t gives `grant_vld = 1` in cycle t+1.
- Handover: the ack that ends a quantum in cycle t makes the new owner visible in cycle t+1, so there is no dead cycle.
- Owner dropping `req` in cycle t: the new owner (or `IDLE`) is visible in cycle t+1.
- `reset_n` asserted mid-burst: outputs clear immediately (asynchronous). The first grant after release follows the reset `ptr`, so `req[0]` has priority.
- With `QUANTUM = 1`, each ack rotates the grant whenever another requester is present.

## Configuration
- Macro: `WRR_ARB_PKT_LOCK_EN`.
- Defined:
  - The count event becomes `ack && tail`, so `QUANTUM` counts whole packets.
  - The owner cannot lose the grant at a non-tail flit through quantum expiry.
  - Release on `req[owner] = 0` still applies.
- Undefined:
  - The count event is `ack`, and the quantum counts flits.
  - `tail` is unused and must not affect state.

## Structure
- Package `noc_arb_pkg` holds:
  - the state enum (`ARB_IDLE`, `ARB_GRANT`);
  - the default `N_REQ` and `QUANTUM` constants;
  - a `clog2`-safe width helper.
- Sub-module `rr_pick`: a combinational circular priority picker. Inputs are `mask[N_REQ]` and `ptr`; outputs are `found`, `idx`, and `oh`. It is instantiated twice: once for the full request vector and once for the vector excluding the owner.

## Test plan
1. Reset with `req = 5'b00001`:
   - While `reset_n = 0`: all outputs are 0.
   - One cycle after release: `grant_idx = 0`, `grant_oh = 5'b00001`.
2. `req = 5'b10110` held, `ack = 1` every cycle:
   - Owners in sequence are 1×4, 2×4, 4×4, 1×4.
   - `grant_vld` never drops.
3. `req = 5'b00100` only, 10 consecutive acks:
   - `grant_idx` stays 2 throughout.
   - `cnt` wraps 3→0 without any grant change.
4. Owner 1 after 2 acks, then `req` changes to `5'b10100`:
   - Next cycle: owner is 2 with `cnt = 0`.
   - Then `req = 0`: `IDLE` the following cycle.
   - Then `req = 5'b00011`: grant goes to 0 (`ptr = 2`, search order 3, 4, 0).
5. `WRR_ARB_PKT_LOCK_EN` defined, `QUANTUM = 1`, `req = 5'b00011`, 3-flit packets acked every cycle:
   - Grant switches 0→1 only in the cycle after the tail ack.
6. Reset asserted mid-quantum (owner 3, `cnt = 2`):
   - Outputs clear asynchronously.
   - After release with `req = 5'b01001`: owner is 0, not 3.
